// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants for the key-schedule block.
//   NB           - columns per state (words per round key)
//   kexp_state_e - key-expansion FSM states (IDLE, EXPAND)
//   SBOX / sbox  - forward S-box table and byte lookup
//   RCON         - round constants, indexed by i/nk (entry 0 unused)
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic {IDLE, EXPAND} kexp_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Padded to 16 entries so a 4-bit round index never leaves the table.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_expansion_seq_if.sv
// key_expansion_seq_if: request/result bundle of the key-schedule generator.
//   start - request expansion (master -> slave)
//   key   - cipher key, word 0 in the top 32 bits (master -> slave)
//   busy  - expansion in progress (slave -> master)
//   done  - one-cycle pulse, schedule complete (slave -> master)
//   w     - flat expanded schedule, word i at w[i*32 +: 32] (slave -> master)
interface key_expansion_seq_if
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
);
  logic                     start;
  logic [nk*32-1:0]         key;
  logic                     busy;
  logic                     done;
  logic [0:(nr+1)*NB*32-1]  w;

  modport master (output start, key, input busy, done, w);
  modport slave  (input start, key, output busy, done, w);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord - applies the AES S-box to each byte of a word.
//   word   - 32-bit input
//   subbed - 32-bit output, byte-wise S-box substitution (pure combinational)
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign subbed[b*8 +: 8] = sbox(word[b*8 +: 8]);
  end
endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES key schedule, one 32-bit word per cycle.
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - key_expansion_seq_if.slave (start/key in, busy/done/w out)
// Parameters nk (4/6/8) and nr (10/12/14, nr = nk+6) select AES-128/192/256.
// Build option KEYEXP_ZEROIZE_EN: the accepting start edge also clears words
// nk and above, so no stale schedule is ever visible during expansion.
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
)(
  input  logic                clk,
  input  logic                reset,
  key_expansion_seq_if.slave  bus
);
  localparam int         WORDS = NB*(nr+1);
  localparam logic [5:0] LAST  = 6'(WORDS-1);
  localparam logic [5:0] NK6   = 6'(nk);

  kexp_state_e              state, state_nxt;
  logic [5:0]               i;
  logic [WORDS-1:0][31:0]   words;
  logic                     done_q;

  logic                     accept, last_word;
  logic [5:0]               kpos;
  logic [3:0]               rnd;
  logic [31:0]              prev, sw_in, sw_out, t;
  logic [nk-1:0][31:0]      key_words;

  // Key word 0 sits at the top of the key bus.
  for (genvar g = 0; g < nk; g++) begin : g_key
    assign key_words[g] = bus.key[(nk-g)*32-1 -: 32];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = EXPAND;
      end
      EXPAND: if (i == LAST) begin
        last_word = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word generator. RotWord is applied ahead of the shared SubWord instance,
  // so one S-box bank serves both the rcon step and the nk>6 mid-key step.
  always_comb begin
    kpos  = i % NK6;
    rnd   = 4'(i / NK6);
    prev  = words[i - 6'd1];
    sw_in = (kpos == 6'd0) ? {prev[23:0], prev[31:24]} : prev;
    t     = prev;
    if (kpos == 6'd0)                 t = sw_out ^ {RCON[rnd], 24'h0};
    else if (nk > 6 && kpos == 6'd4)  t = sw_out;
  end

  aes_sub_word u_sub_word (
    .word   (sw_in),
    .subbed (sw_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      i      <= '0;
      words  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_word;
      if (accept) begin
        words[nk-1:0] <= key_words;
`ifdef KEYEXP_ZEROIZE_EN
        words[WORDS-1:nk] <= '0;
`else
        // Words nk and up keep the previous schedule until overwritten.
`endif
        i <= NK6;
      end else if (state == EXPAND) begin
        words[i] <= words[i - NK6] ^ t;
        i        <= i + 6'd1;
      end
    end
  end

  assign bus.busy = (state == EXPAND);
  assign bus.done = done_q;

  for (genvar g = 0; g < WORDS; g++) begin : g_w
    assign bus.w[g*32 +: 32] = words[g];
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed FIPS-197 vectors for AES-128/192/256, start
// re-pulse while busy, mid-run reset, and back-to-back runs on done.
module tb_key_expansion_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_expansion_seq_if #(.nk(4), .nr(10)) b128 ();
  key_expansion_seq_if #(.nk(6), .nr(12)) b192 ();
  key_expansion_seq_if #(.nk(8), .nr(14)) b256 ();

  key_expansion_seq #(.nk(4), .nr(10)) u128 (.clk(clk), .reset(reset), .bus(b128));
  key_expansion_seq #(.nk(6), .nr(12)) u192 (.clk(clk), .reset(reset), .bus(b192));
  key_expansion_seq #(.nk(8), .nr(14)) u256 (.clk(clk), .reset(reset), .bus(b256));

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10B = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      1:       return b192.done;
      2:       return b256.done;
      default: return b128.done;
    endcase
  endfunction

  // Pulse start for one cycle; returns at the negedge just after the accepting edge.
  task automatic start_run(input int sel, input logic [255:0] k);
    @(negedge clk);
    case (sel)
      1:       begin b192.start = 1'b1; b192.key = k[191:0]; end
      2:       begin b256.start = 1'b1; b256.key = k; end
      default: begin b128.start = 1'b1; b128.key = k[127:0]; end
    endcase
    @(negedge clk);
    b128.start = 1'b0; b192.start = 1'b0; b256.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int sel, input bit repulse, output int lat);
    lat = 0;
    while (!done_of(sel) && lat < 200) begin
      @(negedge clk);
      lat++;
      if (repulse) begin
        b128.start = (lat == 5 || lat == 20);
        b128.key   = K128B;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    b128.start = 1'b0; b128.key = '0;
    b192.start = 1'b0; b192.key = '0;
    b256.start = 1'b0; b256.key = '0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 128'(b128.busy), 128'd0);
    chk("rst_done", 128'(b128.done), 128'd0);
    chk("rst_w_nonzero", 128'(|b128.w), 128'd0);

    // AES-128 with start re-pulsed mid-run using another key
    start_run(0, 256'(K128));
    chk("a128_busy_rise", 128'(b128.busy), 128'd1);
    wait_done(0, 1'b1, lat);
    chk("a128_latency", 128'(lat), 128'd40);
    chk("a128_busy_at_done", 128'(b128.busy), 128'd0);
    chk("a128_rk0", b128.w[0 +: 128], K128);
    chk("a128_w4", 128'(b128.w[4*32 +: 32]), 128'h a0fafe17);
    chk("a128_rk10", b128.w[10*128 +: 128], RK10A);
    @(negedge clk);
    chk("a128_done_width", 128'(b128.done), 128'd0);
    repeat (3) @(negedge clk);
    chk("a128_rk10_hold", b128.w[10*128 +: 128], RK10A);

    // Reset at cycle 15 of a run aborts it
    start_run(0, 256'(K128B));
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 128'(b128.busy), 128'd0);
    chk("abort_w_nonzero", 128'(|b128.w), 128'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      seen |= b128.done;
    end
    chk("abort_no_done", 128'(seen), 128'd0);
    start_run(0, 256'(K128));
    wait_done(0, 1'b0, lat);
    chk("fresh_latency", 128'(lat), 128'd40);
    chk("fresh_rk10", b128.w[10*128 +: 128], RK10A);

    // Back-to-back: start held high through done, second key accepted on done
    @(negedge clk);
    b128.start = 1'b1; b128.key = K128;
    @(negedge clk);
    b128.key = K128B;
    wait_done(0, 1'b0, lat);
    chk("b2b_latency1", 128'(lat), 128'd40);
    chk("b2b_rk10_first", b128.w[10*128 +: 128], RK10A);
    @(negedge clk);
    b128.start = 1'b0;
    chk("b2b_accept_busy", 128'(b128.busy), 128'd1);
    chk("b2b_rk0_second", b128.w[0 +: 128], K128B);
`ifdef KEYEXP_ZEROIZE_EN
    chk("b2b_zeroized", 128'(|b128.w[4*32 +: 40*32]), 128'd0);
`else
    chk("b2b_stale_w4", 128'(b128.w[4*32 +: 32]), 128'h a0fafe17);
`endif
    wait_done(0, 1'b0, lat);
    chk("b2b_latency2", 128'(lat), 128'd40);
    chk("b2b_rk10_second", b128.w[10*128 +: 128], RK10B);

    // AES-192
    start_run(1, 256'(K192));
    wait_done(1, 1'b0, lat);
    chk("a192_latency", 128'(lat), 128'd46);
    chk("a192_w6", 128'(b192.w[6*32 +: 32]), 128'h fe0c91f7);
    chk("a192_w51", 128'(b192.w[51*32 +: 32]), 128'h 01002202);

    // AES-256
    start_run(2, K256);
    wait_done(2, 1'b0, lat);
    chk("a256_latency", 128'(lat), 128'd52);
    chk("a256_w8", 128'(b256.w[8*32 +: 32]), 128'h 9ba35411);
    chk("a256_w12", 128'(b256.w[12*32 +: 32]), 128'h a8b09c1a);
    chk("a256_w59", 128'(b256.w[59*32 +: 32]), 128'h 706c631e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Iterative AES key-schedule generator that turns the cipher key into the full expanded schedule `w`. It computes one 32-bit word per cycle and raises `done` when the schedule is complete. It sits directly upstream of the decryption datapath, which consumes `w` as a flat vector and indexes round key r at `w[r*128 +: 128]`. It supports AES-128/192/256 through `nk`/`nr`.

## Interface
- `nk`, default 4: key length in 32-bit words (4, 6 or 8).
- `nr`, default 10: number of rounds (10, 12 or 14). Must equal nk+6.
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request expansion. Sampled only in IDLE.
- `key`  in  nk*32: cipher key. Bits [nk*32-1 -: 32] are word 0. Captured on the accepted `start`.
- `busy`  out  1: high while expansion is in progress.
- `done`  out  1: one-cycle pulse when the last word is written.
- `w`  out  [0:((nr+1)*128)-1]: expanded schedule. Word i is at `w[i*32 +: 32]`, so word 0 occupies the most-significant end.

## Operation
- FSM states are IDLE and EXPAND. A word counter `i` is 6 bits wide and counts up to 4*(nr+1)-1.
- IDLE with `start`=1, at the same edge:
  - write words 0..nk-1 from `key`;
  - set `i`=nk;
  - go to EXPAND;
  - `busy`=1.
- EXPAND, each cycle:
  - compute t = w[i-1];
  - if i mod nk == 0: t = SubWord(RotWord(t)) ^ {Rcon[i/nk], 24'h0};
  - else if nk>6 and i mod nk == 4: t = SubWord(t);
  - write w[i] = w[i-nk] ^ t, then i = i+1.
- When i == 4*(nr+1)-1 is written: go to IDLE, drop `busy`, pulse `done`.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- `start` while `busy`=1 is ignored. The key is not re-captured and the schedule is not disturbed.
- `start` in the same cycle that `done` is high is accepted. `done` pulses, then the new expansion begins.
- `key` is don't-care after capture. The block uses only stored words.
- `w` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `i`=0, `busy`=0, `done`=0, `w`=all zeros.
- Reset mid-expansion aborts at the next edge and returns to the reset values. No `done` is produced.
- Latency from the edge that accepts `start` to the edge that raises `done` is 4*(nr+1)-nk cycles:
  - 40 for AES-128;
  - 46 for AES-192;
  - 52 for AES-256.
- `done` is high for exactly one cycle. `w` is complete and stable in that cycle and stays stable afterwards.
- `busy` rises in the cycle after the accepting edge and falls in the same cycle `done` rises.
- There are no combinational paths from inputs to outputs.

## Configuration
- `KEYEXP_ZEROIZE_EN` defined:
  - the accepting `start` edge clears words nk..4*(nr+1)-1 to zero;
  - a stale schedule from the previous key is never visible during expansion.
- Not defined:
  - words nk and above keep their previous values until overwritten;
  - only words 0..nk-1 change on the accepting edge.
- `done` timing is identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - `NB`=4;
  - S-box table as a constant array with an `sbox(byte)` function;
  - Rcon constant array;
  - state enum (IDLE, EXPAND).
- One sub-module, `aes_sub_word`: combinational, 32-bit in and out, four S-box lookups.
  - A single instance is shared by the RotWord and plain-SubWord paths.
  - The input is selected before the instance.

## Test plan
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c, `start` 1 cycle:
  - `done` 40 cycles later;
  - w[4]=a0fafe17;
  - round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (A.2, nk=6, nr=12), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - `done` after 46 cycles;
  - w[51]=01002202.
- AES-256 (A.3, nk=8, nr=14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - `done` after 52;
  - w[59]=706c631e (exercises the i mod nk == 4 path).
- `start` re-pulsed at cycles 5 and 20 of an AES-128 run with a different `key`:
  - ignored;
  - `done` still at cycle 40 with the original schedule.
- `reset` asserted at cycle 15, then `start` again:
  - `w` reads all zeros and `busy`=0 after the reset edge;
  - the fresh run completes correctly in 40 cycles.
- Back-to-back runs, second key 000102030405060708090a0b0c0d0e0f, `start` held high through `done`:
  - second run accepted on the `done` cycle;
  - round key 10 = 13111d7fe3944a17f307a78b4d2b30c5;
  - with `KEYEXP_ZEROIZE_EN`, w[4..43]=0 in the cycle after acceptance.
